// File: rtl/ahb_rr_bus_arbiter.sv
// rtl/ahb_rr_bus_arbiter.sv - round-robin AHB main-bus arbiter with burst/lock hold and data-phase tracking
module ahb_rr_bus_arbiter #(
  parameter int MANAGERS = 4,
  parameter int ID_W     = $clog2(MANAGERS)
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [MANAGERS-1:0] req,
  input  logic [MANAGERS-1:0] lock,
  input  logic [1:0]          bus_htrans,
  input  logic [2:0]          bus_hburst,
  input  logic                HREADY,
  output logic [MANAGERS-1:0] grant,
  output logic [ID_W-1:0]     grant_id,
  output logic [ID_W-1:0]     dphase_id,
  output logic                dphase_valid
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0] dphase_id_q, dphase_id_d;
  logic            dphase_valid_q, dphase_valid_d;

  logic [ID_W-1:0] rr_winner;
  logic [ID_W:0]   rr_sum;
  logic [ID_W-1:0] rr_cand;

  state_t          arb_state;
  logic [ID_W-1:0] arb_grant;
  logic [3:0]      arb_cnt;

  // Round-robin search: walk from farthest to nearest so the nearest requester after the owner wins;
  // the current owner is the fallback, which also parks the grant when nobody requests.
  always_comb begin
    rr_winner = grant_id_q;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = MANAGERS - 1; k >= 1; k--) begin
      rr_sum = {1'b0, grant_id_q} + (ID_W+1)'(k);
      if (rr_sum >= (ID_W+1)'(MANAGERS)) begin
        rr_sum = rr_sum - (ID_W+1)'(MANAGERS);
      end
      rr_cand = rr_sum[ID_W-1:0];
      if (req[rr_cand]) begin
        rr_winner = rr_cand;
      end
    end
  end

  // Decision taken when the bus is free to start something new (ARB, or a burst cut short by IDLE/NONSEQ).
  always_comb begin
    arb_state = ST_ARB;
    arb_grant = rr_winner;
    arb_cnt   = 4'd0;
    if (bus_htrans == HTRANS_NONSEQ) begin
      if (lock[grant_id_q]) begin
        arb_state = ST_LOCKED;
        arb_grant = grant_id_q;
      end else if (bus_hburst != HBURST_SINGLE) begin
        arb_state = ST_BURST;
        arb_grant = grant_id_q;
        case (bus_hburst)
          HBURST_WRAP4, HBURST_INCR4:   arb_cnt = 4'd3;
          HBURST_WRAP8, HBURST_INCR8:   arb_cnt = 4'd7;
          HBURST_WRAP16, HBURST_INCR16: arb_cnt = 4'd15;
          default:                      arb_cnt = 4'd0;
        endcase
      end
    end
  end

  // Next-state: every update is gated by HREADY; beat_cnt==0 inside BURST marks an undefined-length INCR.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    beat_cnt_d     = beat_cnt_q;
    dphase_id_d    = dphase_id_q;
    dphase_valid_d = dphase_valid_q;
    if (HREADY) begin
      dphase_id_d    = grant_id_q;
      dphase_valid_d = bus_htrans[1];
      case (state_q)
        ST_ARB: begin
          state_d    = arb_state;
          grant_id_d = arb_grant;
          beat_cnt_d = arb_cnt;
        end
        ST_BURST: begin
          if (bus_htrans == HTRANS_SEQ) begin
            if (beat_cnt_q != 4'd0) begin
              beat_cnt_d = beat_cnt_q - 4'd1;
              if (beat_cnt_q == 4'd1) begin
                state_d    = ST_ARB;
                grant_id_d = rr_winner;
              end
            end
          end else if (bus_htrans != HTRANS_BUSY) begin
            state_d    = arb_state;
            grant_id_d = arb_grant;
            beat_cnt_d = arb_cnt;
          end
        end
        ST_LOCKED: begin
          if (!lock[grant_id_q]) begin
            if (bus_htrans == HTRANS_IDLE) begin
              state_d    = ST_ARB;
              grant_id_d = rr_winner;
              beat_cnt_d = 4'd0;
            end else if (bus_htrans == HTRANS_NONSEQ) begin
              state_d    = arb_state;
              grant_id_d = arb_grant;
              beat_cnt_d = arb_cnt;
            end
          end
        end
        default: begin
          state_d    = ST_ARB;
          beat_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= ST_ARB;
      grant_id_q     <= '0;
      beat_cnt_q     <= 4'd0;
      dphase_id_q    <= '0;
      dphase_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      beat_cnt_q     <= beat_cnt_d;
      dphase_id_q    <= dphase_id_d;
      dphase_valid_q <= dphase_valid_d;
    end
  end

  // One-hot grant decoded from the owner index, so it can never be zero or multi-hot.
  always_comb begin
    grant             = '0;
    grant[grant_id_q] = 1'b1;
  end

  assign grant_id     = grant_id_q;
  assign dphase_id    = dphase_id_q;
  assign dphase_valid = dphase_valid_q;

endmodule

// File: tb/tb_ahb_rr_bus_arbiter.sv
// tb/tb_ahb_rr_bus_arbiter.sv - directed self-checking bench for ahb_rr_bus_arbiter
module tb_ahb_rr_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR8  = 3'd5;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] req;
  logic [3:0] lock;
  logic [1:0] bus_htrans;
  logic [2:0] bus_hburst;
  logic       HREADY;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [1:0] dphase_id;
  logic       dphase_valid;

  int errors = 0;
  int checks = 0;

  ahb_rr_bus_arbiter #(.MANAGERS(4)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (req),
    .lock         (lock),
    .bus_htrans   (bus_htrans),
    .bus_hburst   (bus_hburst),
    .HREADY       (HREADY),
    .grant        (grant),
    .grant_id     (grant_id),
    .dphase_id    (dphase_id),
    .dphase_valid (dphase_valid)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn    = 1'b0;
    req        = 4'b0000;
    lock       = 4'b0000;
    bus_htrans = IDLE;
    bus_hburst = SINGLE;
    HREADY     = 1'b1;
    #2;
    HRESETn    = 1'b1;
  endtask

  task automatic check_gid(input string name, input logic [1:0] exp);
    checks++;
    if (grant_id !== exp || grant !== (4'b0001 << exp)) begin
      errors++;
      $display("FAIL %s: grant_id=%0d grant=%b, required grant_id=%0d", name, grant_id, grant, exp);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req = 4'b1111; lock = 4'b0000; bus_htrans = NONSEQ; bus_hburst = SINGLE; HREADY = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || dphase_id !== 2'd0 || dphase_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: grant=%b id=%0d did=%0d dv=%b, required 0001/0/0/0", grant, grant_id, dphase_id, dphase_valid);
    end
    step();
    checks++;
    if (grant !== 4'b0001 || dphase_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_edge: grant=%b dv=%b, required 0001/0", grant, dphase_valid);
    end
    req = 4'b0000; bus_htrans = IDLE;
    #1 HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL park_no_req[%0d]: grant=%b required 0001", i, grant);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g[5];
    logic [1:0] exp_d[5];
    exp_g = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_d = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111; bus_htrans = NONSEQ; bus_hburst = SINGLE;
    for (int i = 0; i < 5; i++) begin
      step();
      check_gid($sformatf("rr_grant[%0d]", i), exp_g[i]);
      checks++;
      if (dphase_id !== exp_d[i] || dphase_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_dphase[%0d]: did=%0d dv=%b required %0d/1", i, dphase_id, dphase_valid, exp_d[i]);
      end
    end
  endtask

  task automatic test_sparse_req();
    do_reset();
    bus_htrans = IDLE;
    req = 4'b1000; step(); check_gid("sparse_to3", 2'd3);
    req = 4'b0010; step(); check_gid("sparse_wrap_to1", 2'd1);
    step();               check_gid("sparse_self_last", 2'd1);
    req = 4'b0101; step(); check_gid("sparse_next_after1", 2'd2);
    bus_htrans = IDLE; step();
    checks++;
    if (dphase_valid !== 1'b0) begin
      errors++;
      $display("FAIL dphase_idle: dv=%b required 0", dphase_valid);
    end
  endtask

  task automatic test_burst_wait();
    do_reset();
    req = 4'b1111; bus_htrans = IDLE;
    step(); check_gid("b4_owner1", 2'd1);
    bus_htrans = NONSEQ; bus_hburst = INCR4;
    step(); check_gid("b4_beat1", 2'd1);
    bus_htrans = SEQ; HREADY = 1'b0;
    step(); check_gid("b4_wait", 2'd1);
    HREADY = 1'b1;
    step(); check_gid("b4_beat2", 2'd1);
    step(); check_gid("b4_beat3", 2'd1);
    step(); check_gid("b4_beat4_rearb", 2'd2);
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b1111; bus_htrans = IDLE;
    step(); step(); check_gid("lock_owner2", 2'd2);
    lock = 4'b0100; bus_htrans = NONSEQ; bus_hburst = SINGLE;
    for (int i = 0; i < 3; i++) begin
      step(); check_gid($sformatf("lock_hold[%0d]", i), 2'd2);
    end
    lock = 4'b0000; bus_htrans = IDLE;
    step(); check_gid("lock_release", 2'd3);
  endtask

  task automatic test_early_term();
    do_reset();
    req = 4'b1111; bus_htrans = NONSEQ; bus_hburst = INCR8;
    step(); check_gid("i8_beat1", 2'd0);
    bus_htrans = SEQ;
    step(); check_gid("i8_beat2", 2'd0);
    step(); check_gid("i8_beat3", 2'd0);
    bus_htrans = IDLE;
    step(); check_gid("i8_idle_rearb", 2'd1);
  endtask

  task automatic test_incr_undefined();
    do_reset();
    req = 4'b1111; bus_htrans = NONSEQ; bus_hburst = INCR;
    step(); check_gid("incr_start", 2'd0);
    bus_htrans = BUSY;
    step(); check_gid("incr_busy", 2'd0);
    bus_htrans = SEQ;
    for (int i = 0; i < 17; i++) step();
    check_gid("incr_long_hold", 2'd0);
    bus_htrans = NONSEQ; bus_hburst = SINGLE;
    step(); check_gid("incr_end", 2'd1);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1111; bus_htrans = IDLE;
    step(); step(); step(); check_gid("w8_owner3", 2'd3);
    bus_htrans = NONSEQ; bus_hburst = WRAP8;
    step();
    bus_htrans = SEQ;
    step(); check_gid("w8_hold", 2'd3);
    #1 HRESETn = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || dphase_valid !== 1'b0 || dphase_id !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b id=%0d did=%0d dv=%b, required 0001/0/0/0", grant, grant_id, dphase_id, dphase_valid);
    end
    #1 HRESETn = 1'b1;
    step(); check_gid("w8_not_resumed", 2'd1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_sparse_req();
    test_burst_wait();
    test_lock();
    test_early_term();
    test_incr_undefined();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
